// File: rtl/fp16_norm_sequencer.sv
// Multi-cycle normalizer for the half-precision adder: one bit of mantissa shift per
// cycle, with each exponent step done by the shared external inc/dec unit.
module fp16_norm_sequencer #(
   parameter int MANT_W = 12,
   parameter int EXP_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [MANT_W-1:0] mant_in,
   input  logic [EXP_W-1:0]  exp_in,
   output logic              busy,
   output logic              done,
   output logic [MANT_W-2:0] mant_out,
   output logic [EXP_W-1:0]  exp_out,
   output logic              sticky,
   output logic              zero_flag,
   output logic              ovf_flag,
   output logic              inc_sel,
   output logic              inc_cin,
   output logic [EXP_W-1:0]  inc_a,
   input  logic [EXP_W-1:0]  inc_b
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      EVAL   = 3'd1,
      RSHIFT = 3'd2,
      LSHIFT = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
   localparam logic [EXP_W-1:0] EXP_MAX = '1;

   state_t              state, state_nx;
   logic [MANT_W-1:0]   mant;
   logic [EXP_W-1:0]    exp;

   // Next-state decision; LSHIFT looks at the post-shift values (mant[9] becomes the hidden bit).
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = EVAL;
         EVAL: begin
            if (mant == '0)           state_nx = DONE;
            else if (mant[MANT_W-1])  state_nx = RSHIFT;
            else if (mant[MANT_W-2])  state_nx = DONE;
            else if (exp <= EXP_ONE)  state_nx = DONE;
            else                      state_nx = LSHIFT;
         end
         RSHIFT:  state_nx = DONE;
         LSHIFT:  if (mant[MANT_W-3] || (inc_b == EXP_ONE)) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mant      <= '0;
         exp       <= '0;
         sticky    <= 1'b0;
         zero_flag <= 1'b0;
         ovf_flag  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         inc_sel   <= 1'b0;
         inc_cin   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mant      <= mant_in;
                  // A zero biased exponent means denormal, whose effective exponent is 1.
                  exp       <= (exp_in == '0) ? EXP_ONE : exp_in;
                  sticky    <= 1'b0;
                  zero_flag <= 1'b0;
                  ovf_flag  <= 1'b0;
               end
            end
            EVAL: begin
               if (mant == '0) begin
                  exp       <= '0;
                  zero_flag <= 1'b1;
               end
            end
            RSHIFT: begin
               sticky <= sticky | mant[0];
               exp    <= inc_b;
               if (inc_b == EXP_MAX) begin
                  ovf_flag <= 1'b1;
                  mant     <= '0;
               end else begin
                  mant <= mant >> 1;
               end
            end
            LSHIFT: begin
               mant <= mant << 1;
               exp  <= inc_b;
            end
            default: ;
         endcase

         state   <= state_nx;
         busy    <= (state_nx != IDLE);
         done    <= (state_nx == DONE);
         inc_sel <= (state_nx == RSHIFT) || (state_nx == LSHIFT);
         inc_cin <= (state_nx == LSHIFT);
      end
   end

   assign inc_a = exp;

   // Overflow forces infinity; a missing hidden bit or zero result packs exponent 0.
   always_comb begin
      mant_out = mant[MANT_W-2:0];
      exp_out  = exp;
      if (ovf_flag) begin
         mant_out = '0;
         exp_out  = EXP_MAX;
      end else if (!mant[MANT_W-2] || zero_flag) begin
         exp_out = '0;
      end
   end

endmodule

// File: tb/tb_fp16_norm_sequencer.sv
// Randomized bench for fp16_norm_sequencer with a leading-zero-count reference model
// and a behavioural inc/dec unit on the inc_a/inc_b side.
module tb_fp16_norm_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [11:0] mant_in;
   logic [4:0]  exp_in;
   logic        busy, done, sticky, zero_flag, ovf_flag, inc_sel, inc_cin;
   logic [10:0] mant_out;
   logic [4:0]  exp_out, inc_a, inc_b;

   int total = 0;
   int bad   = 0;

   fp16_norm_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .mant_in(mant_in), .exp_in(exp_in),
      .busy(busy), .done(done), .mant_out(mant_out), .exp_out(exp_out),
      .sticky(sticky), .zero_flag(zero_flag), .ovf_flag(ovf_flag),
      .inc_sel(inc_sel), .inc_cin(inc_cin), .inc_a(inc_a), .inc_b(inc_b)
   );

   always #5 clk = ~clk;

   assign inc_b = inc_sel ? (inc_cin ? inc_a - 5'd1 : inc_a + 5'd1) : inc_a;

   typedef struct {
      logic [10:0] m;
      logic [4:0]  e;
      logic        s, z, o;
      int          lat, nl, nr;
   } res_t;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      if (obs !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, want);
      end
   endtask

   // Normalization from the rules: count leading zeros, clamp at effective exponent 1.
   function automatic res_t model(input logic [11:0] m, input logic [4:0] e);
      res_t r;
      int ee, p, k, mv;
      r  = '{m: '0, e: '0, s: 1'b0, z: 1'b0, o: 1'b0, lat: 0, nl: 0, nr: 0};
      ee = (e == 0) ? 1 : int'(e);
      if (m == 0) begin
         r.z = 1'b1; r.lat = 2;
      end else if (m[11]) begin
         r.nr = 1; r.lat = 3; r.s = m[0];
         if (ee + 1 == 31) begin r.o = 1'b1; r.e = 5'd31; r.m = '0; end
         else begin r.m = m[11:1]; r.e = 5'(ee + 1); end
      end else begin
         p = 0;
         for (int i = 0; i < 11; i++) if (m[i]) p = i;
         k = 10 - p;
         if (k > ee - 1) k = ee - 1;
         mv = int'(m) << k;
         r.m = mv[10:0]; r.nl = k; r.lat = 2 + k;
         r.e = mv[10] ? 5'(ee - k) : 5'd0;
      end
      return r;
   endfunction

   task automatic run_op(input logic [11:0] m, input logic [4:0] e, input bit hold);
      res_t r;
      int cyc, nl, nr;
      r = model(m, e);
      @(negedge clk);
      mant_in = m; exp_in = e; start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
      chk("busy_after_accept", busy, 1'b1);
      cyc = 1; nl = 0; nr = 0;
      while (!done && cyc < 40) begin
         if (inc_sel && inc_cin) nl++;
         if (inc_sel && !inc_cin) nr++;
         if (hold) begin
            mant_in = 12'($urandom);
            exp_in  = 5'($urandom_range(0, 30));
         end
         @(negedge clk);
         cyc++;
      end
      chk("latency", cyc, r.lat);
      chk("lshift_cycles", nl, r.nl);
      chk("rshift_cycles", nr, r.nr);
      chk("busy_in_done", busy, 1'b1);
      chk("inc_sel_in_done", inc_sel, 1'b0);
      chk("mant_out", mant_out, r.m);
      chk("exp_out", exp_out, r.e);
      chk("sticky", sticky, r.s);
      chk("zero_flag", zero_flag, r.z);
      chk("ovf_flag", ovf_flag, r.o);
      start = 1'b0;
      @(negedge clk);
      chk("done_pulse", done, 1'b0);
      chk("busy_idle", busy, 1'b0);
      chk("mant_held", mant_out, r.m);
      chk("exp_held", exp_out, r.e);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mant_in = '0; exp_in = '0;
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_incsel", inc_sel, 1'b0);
      chk("rst_mant", mant_out, 11'd0);
      chk("rst_exp", exp_out, 5'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_op(12'h400, 5'd15, 1'b0);
      run_op(12'hC01, 5'd14, 1'b0);
      run_op(12'h800, 5'd30, 1'b0);
      run_op(12'h020, 5'd20, 1'b0);
      run_op(12'h010, 5'd3,  1'b0);
      run_op(12'h000, 5'd9,  1'b0);
      run_op(12'h001, 5'd30, 1'b0);
      run_op(12'h123, 5'd0,  1'b0);
      run_op(12'h020, 5'd20, 1'b1);
      run_op(12'hC01, 5'd14, 1'b1);

      // Reset in the middle of a long left-shift run.
      @(negedge clk);
      mant_in = 12'h001; exp_in = 5'd30; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_incsel", inc_sel, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_incsel", inc_sel, 1'b0);
      chk("mid_rst_inccin", inc_cin, 1'b0);
      chk("mid_rst_mant", mant_out, 11'd0);
      chk("mid_rst_inca", inc_a, 5'd0);
      @(negedge clk);
      rst = 1'b0;
      begin
         int seen = 0;
         repeat (12) begin
            @(negedge clk);
            if (done) seen++;
         end
         chk("no_done_after_rst", seen, 0);
      end
      run_op(12'h400, 5'd15, 1'b0);

      for (int n = 0; n < 150; n++) begin
         logic [11:0] m;
         logic [4:0]  e;
         case ($urandom_range(0, 4))
            0:       m = 12'h000;
            1:       m = 12'h800 | 12'($urandom_range(0, 12'h7FF));
            2:       m = 12'h400 | 12'($urandom_range(0, 12'h3FF));
            default: m = 12'($urandom_range(1, 12'h3FF)) >> $urandom_range(0, 9);
         endcase
         if (m == 0 && n[0]) m = 12'h001;
         e = 5'($urandom_range(0, 30));
         run_op(m, e, ($urandom_range(0, 3) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp16_norm_sequencer.md
Name: fp16_norm_sequencer

Overview:
- Multi-cycle normalization controller for the half-precision adder. Sits after the mantissa add/subtract stage and before packing.
- Normalizes the 12-bit raw sum mantissa one bit position per cycle.
- Sequences the shared 5-bit exponent increment/decrement unit (select/Cin datapath) for each exponent step, and flags zero, overflow and denormal results.

Parameters:
- MANT_W, 12, raw mantissa width (bit 11 = carry, bit 10 = hidden, bits 9:0 = fraction); only 12 is supported.
- EXP_W, 5, exponent width; only 5 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- mant_in  input  12  raw sum mantissa.
- exp_in  input  5  biased exponent of the sum.
- busy  output  1  high from the cycle after start is accepted through DONE.
- done  output  1  one-cycle pulse; results are valid from this cycle and held until the next accepted start.
- mant_out  output  11  normalized mantissa (hidden bit plus 10 fraction bits).
- exp_out  output  5  result exponent.
- sticky  output  1  OR of all bits shifted out on a right shift.
- zero_flag  output  1  result is zero.
- ovf_flag  output  1  exponent overflowed to 31 (infinity).
- inc_sel  output  1  to the inc/dec unit select: 1 = change exponent, 0 = hold.
- inc_cin  output  1  to the inc/dec unit Cin: 0 = +1, 1 = -1.
- inc_a  output  5  to the inc/dec unit operand; always equals the exponent register.
- inc_b  input  5  combinational result returned by the inc/dec unit in the same cycle.

Behaviour:
- Reset: rst asserted drives state to IDLE and clears all registers and outputs to 0, including inc_sel and inc_cin. Reset mid-operation abandons the operation; no done pulse is issued.
- States: IDLE, EVAL, RSHIFT, LSHIFT, DONE.
- busy = (state != IDLE). done = (state == DONE).
- Inc/dec drive: inc_sel=1 only in RSHIFT (inc_cin=0) and LSHIFT (inc_cin=1); inc_sel=0 and inc_cin=0 in all other states.
- Exponent update: in RSHIFT and LSHIFT, the exponent register loads inc_b at the clock edge.
- IDLE:
  - On start=1, latch mant_in and exp_in, then go to EVAL.
  - exp_in=0 is latched as 1 (denormal effective exponent).
  - sticky, zero_flag and ovf_flag clear on accept.
- EVAL (one cycle, decision only):
  - mant==0: exp<=0, zero_flag<=1, go to DONE.
  - mant[11]=1: go to RSHIFT.
  - mant[11:10]=01: go to DONE.
  - mant[10]=0 and exp<=1: go to DONE (denormal result).
  - Otherwise: go to LSHIFT.
- RSHIFT (one cycle):
  - mant<=mant>>1; sticky<=sticky|mant[0]; exp<=inc_b (exp+1).
  - If inc_b==31: ovf_flag<=1, mant<=0.
  - Go to DONE.
- LSHIFT (repeats, one bit per cycle):
  - mant<=mant<<1 (zero fill); exp<=inc_b (exp-1).
  - Next state is computed on the post-shift values.
  - Post-shift mant[10]=1: go to DONE.
  - Post-shift exp==1: go to DONE (denormal).
  - Otherwise: stay in LSHIFT.
  - At most 10 iterations.
- DONE: lasts one cycle, then IDLE. start is ignored here and everywhere except IDLE.
- Output rule: mant_out = mant[10:0]. exp_out = 0 if mant[10]==0 or zero_flag; otherwise exp_out = exp. With ovf_flag: exp_out=31, mant_out=0.
- Latency: start edge to done = 2 cycles if already normal, zero or denormal; 3 cycles for a right shift; 2+k cycles for k left shifts.
- Exponent arithmetic wraps mod 32 inside the inc/dec unit. Wrap cannot occur: increment is checked at 31 and decrement stops at 1.

Test Plan:
- Reset: assert rst mid-LSHIFT -> all outputs 0 and state IDLE immediately; no done; next start works normally.
- Already normal: mant=0x400, exp=15 -> done 2 cycles after start; mant_out=0x400, exp_out=15, inc_sel never 1.
- Carry-out: mant=0xC01, exp=14 -> done at cycle 3; mant_out=0x600, exp_out=15, sticky=1. Then mant=0x800, exp=30 -> ovf_flag=1, exp_out=31, mant_out=0.
- Left shifts: mant=0x020, exp=20 -> 5 LSHIFT cycles with inc_sel=1, inc_cin=1; done at cycle 7; mant_out=0x400, exp_out=15.
- Underflow stop: mant=0x010, exp=3 -> 2 shifts; done at cycle 4; mant_out=0x040, exp_out=0. Also mant=0, exp=9 -> zero_flag=1, exp_out=0.
- Handshake: start held high through busy and done -> exactly one operation per IDLE acceptance; start during busy does not change the latched operands.
